// File: rtl/layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : layer_sequencer
// Description : Control FSM that time-multiplexes one shared MAC unit across
//               a full neural-network layer (N_IN inputs x N_OUT neurons).
//               Per neuron: clear accumulator, step every input/weight pair,
//               write the result to the output register file; then pulse Done.
//               Optional bias step enabled by defining LAYER_SEQ_BIAS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module layer_sequencer #(
    parameter int N_IN  = 10,
    parameter int N_OUT = 5,
    parameter int AW    = 6,
    parameter int IW    = 4,
    parameter int OW    = 3
) (
    input  logic          Clock,
    input  logic          Rst,
    input  logic          Start,
    input  logic          Stall,
    output logic          Busy,
    output logic          Done,
    output logic [IW-1:0] in_sel,
    output logic [AW-1:0] w_addr,
    output logic          mac_clr,
    output logic          mac_en,
    output logic          bias_sel,
    output logic          out_we,
    output logic [OW-1:0] out_idx
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_MAC   = 3'd2,
        S_BIAS  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_stateNext;
    logic [IW-1:0] r_i;
    logic [IW-1:0] w_iNext;
    logic [OW-1:0] r_n;
    logic [OW-1:0] w_nNext;
    logic [AW-1:0] r_addrHold;
    logic [AW-1:0] w_addrLive;
    logic          w_isMac;
    logic          w_isBias;
    logic          w_stepping;

    assign w_isMac = (r_state == S_MAC);
`ifdef LAYER_SEQ_BIAS_EN
    assign w_isBias = (r_state == S_BIAS);
`else
    assign w_isBias = 1'b0;
`endif
    assign w_stepping = w_isMac | w_isBias;

    // Weight address for the current MAC step or bias step.
    always_comb begin
        w_addrLive = r_addrHold;
        if (w_isMac) begin
            w_addrLive = AW'(r_n) * AW'(N_IN) + AW'(r_i);
        end else if (w_isBias) begin
            w_addrLive = AW'(N_IN * N_OUT) + AW'(r_n);
        end
    end

    // State and counter registers.
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            r_state <= S_IDLE;
            r_i     <= '0;
            r_n     <= '0;
        end else begin
            r_state <= w_stateNext;
            r_i     <= w_iNext;
            r_n     <= w_nNext;
        end
    end

    // Keeps w_addr stable outside the stepping states.
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            r_addrHold <= '0;
        end else if (w_stepping) begin
            r_addrHold <= w_addrLive;
        end
    end

    // Next-state and counter update; Stall only freezes the stepping states.
    always_comb begin
        w_stateNext = r_state;
        w_iNext     = r_i;
        w_nNext     = r_n;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_stateNext = S_CLR;
                    w_nNext     = '0;
                end
            end
            S_CLR: begin
                w_iNext     = '0;
                w_stateNext = S_MAC;
            end
            S_MAC: begin
                if (!Stall) begin
                    if (r_i == IW'(N_IN - 1)) begin
`ifdef LAYER_SEQ_BIAS_EN
                        w_stateNext = S_BIAS;
`else
                        w_stateNext = S_WRITE;
`endif
                    end else begin
                        w_iNext = r_i + 1'b1;
                    end
                end
            end
            S_BIAS: begin
                if (!Stall) begin
                    w_stateNext = S_WRITE;
                end
            end
            S_WRITE: begin
                if (r_n == OW'(N_OUT - 1)) begin
                    w_stateNext = S_DONE;
                end else begin
                    w_nNext     = r_n + 1'b1;
                    w_stateNext = S_CLR;
                end
            end
            S_DONE: begin
                w_stateNext = S_IDLE;
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // Output decode. r_i only changes in CLR/MAC and stops at N_IN-1, so it
    // already holds its last value outside MAC and can drive in_sel directly.
    assign Busy     = (r_state != S_IDLE);
    assign Done     = (r_state == S_DONE);
    assign mac_clr  = (r_state == S_CLR);
    assign out_we   = (r_state == S_WRITE);
    assign out_idx  = (r_state == S_IDLE) ? '0 : r_n;
    assign in_sel   = r_i;
    assign w_addr   = w_stepping ? w_addrLive : r_addrHold;
    assign mac_en   = w_stepping & ~Stall;
`ifdef LAYER_SEQ_BIAS_EN
    assign bias_sel = w_isBias & ~Stall;
`else
    assign bias_sel = 1'b0;
`endif

endmodule
`default_nettype wire
